// File: rtl/binary_to_one_hot_pulser_if.sv
// Handshake and one-hot output bundle for binary_to_one_hot_pulser.
// The master side supplies indices and the slave side drives the one-hot lines.
`timescale 1ns/1ps
interface binary_to_one_hot_pulser_if #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int INPUT_WIDTH  = $clog2(OUTPUT_WIDTH)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [INPUT_WIDTH-1:0]  binary_in;
    logic [OUTPUT_WIDTH-1:0] one_hot_out;
    logic                    out_active;
    logic                    err_range;

    modport master (
        output in_valid, binary_in,
        input  in_ready, one_hot_out, out_active, err_range
    );

    modport slave (
        input  in_valid, binary_in,
        output in_ready, one_hot_out, out_active, err_range
    );
endinterface

// File: rtl/binary_to_one_hot_pulser.sv
// Registered binary-to-one-hot driver: each accepted index drives its line for
// HOLD_CYCLES cycles, then the output is forced to zero for GAP_CYCLES cycles.
`timescale 1ns/1ps
module binary_to_one_hot_pulser #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int INPUT_WIDTH  = $clog2(OUTPUT_WIDTH),
    parameter int HOLD_CYCLES  = 1,
    parameter int GAP_CYCLES   = 0
) (
    input logic                       clk,
    input logic                       rst,
    binary_to_one_hot_pulser_if.slave bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [OUTPUT_WIDTH-1:0] LINE0 = OUTPUT_WIDTH'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]              state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [OUTPUT_WIDTH-1:0] one_hot, one_hot_n;
    logic                    active;
    logic                    err, err_n;

    logic [INPUT_WIDTH-1:0]  index;
    logic                    ready;
    logic                    take;
    logic                    in_range;

    assign index    = bus.binary_in;
    // Range test happens before the shift so no line beyond OUTPUT_WIDTH can be set.
    assign in_range = ({{(32-INPUT_WIDTH){1'b0}}, index} < 32'(OUTPUT_WIDTH));

    // Ready depends only on state and counter, never on in_valid.
    assign ready = (state == ST_IDLE)
                 | ((state == ST_HOLD) && (cnt == '0) && (GAP_CYCLES == 0))
                 | ((state == ST_GAP)  && (cnt == '0));
    assign take  = bus.in_valid && ready;

    always_comb begin
        // NOTE: every target gets a default first, so no path through the case can infer a latch.
        state_n   = state;
        cnt_n     = cnt;
        one_hot_n = one_hot;
        err_n     = 1'b0;

        if (ready) begin
            if (take && in_range) begin
                one_hot_n = LINE0 << index;
                cnt_n     = HOLD_LOAD;
                state_n   = ST_HOLD;
            end else begin
                one_hot_n = '0;
                cnt_n     = '0;
                state_n   = ST_IDLE;
                err_n     = take;
            end
        end else if (cnt != '0) begin
            cnt_n = cnt - CNT_ONE;
        end else begin
            // Only reachable at the end of a hold when a gap is configured.
            one_hot_n = '0;
            cnt_n     = GAP_LOAD;
            state_n   = ST_GAP;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            one_hot <= '0;
            active  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            one_hot <= one_hot_n;
            active  <= |one_hot_n;
            err     <= err_n;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.one_hot_out = one_hot;
    assign bus.out_active  = active;
    assign bus.err_range   = err;
endmodule
